// File: rtl/sync_fifo_pkg.sv
// Shared FIFO types and pointer helpers for the sync FIFO family.
// Pure declarations; no latency or backpressure of its own.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_FWFT = 1'b0,
        FIFO_REG  = 1'b1
    } fifo_mode_e;

    // Explicit wrap so non-power-of-two depths never walk past the last entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ext_if.sv
// Handshake/data bundle of sync_fifo_ext; slave = FIFO side, master = producer/consumer side.
// Wires only; no latency, no backpressure logic.
interface sync_fifo_ext_if #(
    parameter int DW = 8,
    parameter int DP = 8
);
    localparam int AW = $clog2(DP);

    logic          flush;
    logic          push;
    logic [DW-1:0] i_data;
    logic          full;
    logic          almost_full;
    logic          pop;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, push, i_data, pop,
        input  full, almost_full, o_data, o_valid, empty, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, push, i_data, pop,
        output full, almost_full, o_data, o_valid, empty, almost_empty,
               level, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
// Write visible to the read port one edge after we; no backpressure of its own.
module fifo_ram #(
    parameter int DW = 8,
    parameter int DP = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [$clog2(DP)-1:0] waddr,
    input  logic [DW-1:0]         wdata,
    input  logic [$clog2(DP)-1:0] raddr,
    output logic [DW-1:0]         rdata
);

    logic [DW-1:0] mem [DP];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO, any depth >= 2, FWFT or registered read, thresholds and sticky error flags.
// Write latency 1; read latency 0 (FWFT) or 1 (REG); push while full / pop while empty are dropped.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DP    = 8,
    parameter int MODE  = 0,
    parameter int AF_TH = DP - 1,
    parameter int AE_TH = 1
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_ext_if.slave bus
);

    localparam int AW = $clog2(DP);

    if (DP < 2) begin : g_bad_dp
        $error("sync_fifo_ext: DP must be >= 2");
    end
    if (AF_TH < 1 || AF_TH > DP) begin : g_bad_af
        $error("sync_fifo_ext: AF_TH must be within 1..DP");
    end
    if (AE_TH < 0 || AE_TH > DP - 1) begin : g_bad_ae
        $error("sync_fifo_ext: AE_TH must be within 0..DP-1");
    end
    if (MODE != int'(FIFO_FWFT) && MODE != int'(FIFO_REG)) begin : g_bad_mode
        $error("sync_fifo_ext: MODE must be 0 (FWFT) or 1 (REG)");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;
    logic [DW-1:0] rd_data;

    // All status is decoded from the registered level, so it reflects pre-edge state.
    assign full    = (level_q == (AW+1)'(DP));
    assign empty   = (level_q == '0);
    assign push_ok = bus.push & ~full  & ~bus.flush;
    assign pop_ok  = bus.pop  & ~empty & ~bus.flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DP));
            end
            if (pop_ok) begin
                rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DP));
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            overflow_d  = overflow_q  | (bus.push & full);
            underflow_d = underflow_q | (bus.pop  & empty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DW (DW),
        .DP (DP)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.i_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    if (MODE == int'(FIFO_REG)) begin : g_reg
        logic          o_valid_q, o_valid_d;
        logic [DW-1:0] o_data_q,  o_data_d;

        // pop_ok is already masked by flush, so a flush drops o_valid and holds o_data.
        always_comb begin
            o_valid_d = pop_ok;
            o_data_d  = pop_ok ? rd_data : o_data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_valid_q <= 1'b0;
                o_data_q  <= '0;
            end else begin
                o_valid_q <= o_valid_d;
                o_data_q  <= o_data_d;
            end
        end

        assign bus.o_valid = o_valid_q;
        assign bus.o_data  = o_data_q;
    end else begin : g_fwft
        assign bus.o_valid = ~empty;
        assign bus.o_data  = empty ? '0 : rd_data;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= (AW+1)'(AF_TH));
    assign bus.almost_empty = (level_q <= (AW+1)'(AE_TH));
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Drives one FWFT and one REG instance with identical stimulus; a queue model predicts status
// and a negedge monitor scores read data against per-instance expectation queues.
module tb_sync_fifo_ext;

    localparam int DW = 8;
    localparam int DP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push_r = 1'b0, pop_r = 1'b0, flush_r = 1'b0;
    logic [DW-1:0] din_r = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [$];
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    bit            m_ovf, m_udf, m_regv;
    logic [DW-1:0] m_last;

    always #5 clk = ~clk;

    sync_fifo_ext_if #(.DW(DW), .DP(DP)) bus0 ();
    sync_fifo_ext_if #(.DW(DW), .DP(DP)) bus1 ();

    assign bus0.push = push_r;  assign bus0.pop = pop_r;
    assign bus0.flush = flush_r; assign bus0.i_data = din_r;
    assign bus1.push = push_r;  assign bus1.pop = pop_r;
    assign bus1.flush = flush_r; assign bus1.i_data = din_r;

    sync_fifo_ext #(.DW(DW), .DP(DP), .MODE(0), .AF_TH(4), .AE_TH(1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    sync_fifo_ext #(.DW(DW), .DP(DP), .MODE(1), .AF_TH(4), .AE_TH(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag, input logic [3:0] lvl, input logic f,
                                input logic e, input logic af, input logic ae,
                                input logic ov, input logic ud);
        int n = mq.size();
        chk({tag, "_level"}, 32'(lvl), 32'(n));
        chk({tag, "_full"},  32'(f),   32'(n == DP));
        chk({tag, "_empty"}, 32'(e),   32'(n == 0));
        chk({tag, "_afull"}, 32'(af),  32'(n >= 4));
        chk({tag, "_aempty"},32'(ae),  32'(n <= 1));
        chk({tag, "_ovf"},   32'(ov),  32'(m_ovf));
        chk({tag, "_udf"},   32'(ud),  32'(m_udf));
    endtask

    task automatic check_state();
        check_status("fwft", bus0.level, bus0.full, bus0.empty, bus0.almost_full,
                     bus0.almost_empty, bus0.overflow, bus0.underflow);
        check_status("reg", bus1.level, bus1.full, bus1.empty, bus1.almost_full,
                     bus1.almost_empty, bus1.overflow, bus1.underflow);
        chk("fwft_o_valid", 32'(bus0.o_valid), 32'(mq.size() != 0));
        chk("fwft_o_data",  32'(bus0.o_data),  (mq.size() == 0) ? 32'd0 : 32'(mq[0]));
        chk("reg_o_valid",  32'(bus1.o_valid), 32'(m_regv));
        chk("reg_o_data",   32'(bus1.o_data),  32'(m_last));
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit q, input bit f);
        bit was_full  = (mq.size() == DP);
        bit was_empty = (mq.size() == 0);
        bit rd_ok     = q && !was_empty && !f;
        push_r = p; din_r = d; pop_r = q; flush_r = f;
        if (rd_ok) begin
            exp0.push_back(mq[0]);
            exp1.push_back(mq[0]);
        end
        @(posedge clk);
        #1;
        m_regv = rd_ok;
        if (f) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (rd_ok) m_last = mq.pop_front();
            if (p && !was_full) mq.push_back(d);
            if (p && was_full)  m_ovf = 1;
            if (q && was_empty) m_udf = 1;
        end
        push_r = 0; pop_r = 0; flush_r = 0;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete(); exp0.delete(); exp1.delete();
        m_ovf = 0; m_udf = 0; m_regv = 0; m_last = '0;
        check_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Scoreboard monitor: FWFT word is consumed while displayed, REG word appears one edge later.
    always @(negedge clk) begin
        if (!rst) begin
            if (pop_r && !flush_r && bus0.o_valid) begin
                if (exp0.size() == 0) chk("fwft_unexpected_read", 32'd1, 32'd0);
                else chk("fwft_rd_data", 32'(bus0.o_data), 32'(exp0.pop_front()));
            end
            if (bus1.o_valid) begin
                if (exp1.size() == 0) chk("reg_unexpected_read", 32'd1, 32'd0);
                else chk("reg_rd_data", 32'(bus1.o_data), 32'(exp1.pop_front()));
            end
        end
    end

    initial begin
        m_last = '0;
        do_reset();

        // Fill/drain with overflow on the sixth push.
        for (int i = 1; i <= 5; i++) step(1, 8'(i * 8'h11), 0, 0);
        step(1, 8'h66, 0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Wrap across the non-power-of-two boundary.
        step(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'hB0 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

        // Simultaneous push+pop at level 2, 3 and full.
        step(1, 8'hC0, 0, 0); step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 1, 0);
        step(1, 8'hC3, 0, 0);
        step(1, 8'hC4, 1, 0);
        step(1, 8'hC5, 0, 0); step(1, 8'hC6, 0, 0);
        step(1, 8'hC7, 1, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        // Registered read: A5 then 5A with idle cycles between.
        step(0, '0, 0, 1);
        step(1, 8'hA5, 0, 0); step(1, 8'h5A, 0, 0);
        step(0, '0, 1, 0); step(0, '0, 0, 0); step(0, '0, 0, 0);
        step(0, '0, 1, 0); step(0, '0, 0, 0);

        // Flush wins over push+pop at level 3 with overflow set.
        for (int i = 0; i < 6; i++) step(1, 8'(8'hD0 + i), 0, 0);
        step(0, '0, 1, 0); step(0, '0, 1, 0);
        step(1, 8'hEE, 1, 1);
        step(0, '0, 0, 0);

        // Asynchronous reset mid-stream at level 3.
        for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 0, 0);
        do_reset();

        // Randomised traffic with phase-varying push/pop bias.
        for (int seg = 0; seg < 12; seg++) begin
            int pp = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 20 : 50;
            for (int i = 0; i < 40; i++) begin
                step($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 99) >= pp,
                     $urandom_range(0, 39) == 0);
            end
        end
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);

        chk("fwft_exp_drained", 32'(exp0.size()), 32'd0);
        chk("reg_exp_drained",  32'(exp1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
